// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the control decoder.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package instr_encoder_pkg;

   // Descriptor kind codes carried on in_kind
   localparam logic [2:0] KIND_R       = 3'd0;
   localparam logic [2:0] KIND_LW      = 3'd1;
   localparam logic [2:0] KIND_SW      = 3'd2;
   localparam logic [2:0] KIND_BEQ     = 3'd3;
   localparam logic [2:0] KIND_ADDI    = 3'd4;
   localparam logic [2:0] KIND_ORI     = 3'd5;
   localparam logic [2:0] KIND_J       = 3'd6;
   localparam logic [2:0] KIND_ILLEGAL = 3'd7;

   // Primary opcodes, bits [31:26]; the control decoder imports these same values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // sll $0,$0,0 encodes as all zeros and is the canonical nop
   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   // Load-control states; PAD exists only when nop padding is built in
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FULL
`ifdef INSTR_ENCODER_NOP_PAD_EN
      ,
      ST_PAD
`endif
   } state_e;

endpackage : instr_encoder_pkg

// File: rtl/instr_pack.sv
// Packs one instruction descriptor into a 32-bit MIPS word; flags kinds with no encoding.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        illegal
);

   // Select the field layout by kind; fields not in the format are ignored
   always_comb begin
      word    = INSTR_NOP;
      illegal = 1'b0;
      case (kind)
         KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
         KIND_LW:   word = {OP_LW,   rs, rt, imm};
         KIND_SW:   word = {OP_SW,   rs, rt, imm};
         KIND_BEQ:  word = {OP_BEQ,  rs, rt, imm};
         KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
         KIND_ORI:  word = {OP_ORI,  rs, rt, imm};
         KIND_J:    word = {OP_J, target};
         default:   illegal = 1'b1;
      endcase
   end

endmodule : instr_pack

// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into sequentially addressed words for instruction-memory fill.
// Latency: one cycle from input accept to out_valid; one word per cycle sustained.
// Backpressure: in_ready drops while a held output word is stalled; optional nop padding
// is enabled with the INSTR_ENCODER_NOP_PAD_EN macro (adds the flush input).
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
`ifdef INSTR_ENCODER_NOP_PAD_EN
   input  logic              flush,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              done,
   output logic              err
);

   // Counter is one bit wider than the address so it can reach DEPTH itself
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

   state_e            state_q,     state_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
   logic [ADDR_W:0]   count_q,     count_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;

   logic [31:0] pack_word;
   logic        pack_illegal;
   logic        slot_free;
   logic        flush_req;
   logic        accept;

   instr_pack u_pack (
      .kind    (in_kind),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .funct   (in_funct),
      .imm     (in_imm),
      .target  (in_target),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

`ifdef INSTR_ENCODER_NOP_PAD_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // Output slot can take a new word if empty or being drained this cycle.
   // start and flush both win over a same-cycle descriptor, so they block the accept.
   always_comb begin
      slot_free = !out_valid_q || out_ready;
      in_ready  = (state_q == ST_RUN) && slot_free && !start && !flush_req;
      accept    = in_valid && in_ready;
   end

   // Next-state computation for the load FSM, counter and output register
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_addr_d  = out_addr_q;
      count_d     = count_q;
      err_d       = err_q;

      if (start) begin
         // A pending word is dropped; the load restarts at address 0
         state_d     = ST_RUN;
         out_valid_d = 1'b0;
         count_d     = '0;
         err_d       = 1'b0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RUN: begin
               if (accept) begin
                  if (pack_illegal) begin
                     // Consumed but not emitted; address sequence stays dense
                     err_d = 1'b1;
                  end else begin
                     out_valid_d = 1'b1;
                     out_instr_d = pack_word;
                     out_addr_d  = count_q[ADDR_W-1:0];
                     count_d     = count_q + CNT_ONE;
                     if (count_q == LAST_IDX) begin
                        state_d = ST_FULL;
                     end
                  end
               end
`ifdef INSTR_ENCODER_NOP_PAD_EN
               else if (flush_req) begin
                  state_d = ST_PAD;
               end
`endif
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            ST_PAD: begin
               // Fill the remaining addresses with nops, one per free output slot
               if (slot_free) begin
                  out_valid_d = 1'b1;
                  out_instr_d = INSTR_NOP;
                  out_addr_d  = count_q[ADDR_W-1:0];
                  count_d     = count_q + CNT_ONE;
                  if (count_q == LAST_IDX) begin
                     state_d = ST_FULL;
                  end
               end
            end
`endif
            ST_FULL: begin
               state_d = ST_FULL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // done is registered and rises together with the final word leaving
      done_d = (state_d == ST_FULL) && !out_valid_d;
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_addr_q  <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_addr_q  <= out_addr_d;
         count_q     <= count_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = out_addr_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule : instr_encoder

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder, built with DEPTH=4 / ADDR_W=2.
// Latency: checks the one-cycle accept-to-output path and FULL/done timing.
// Backpressure: exercises out_ready stalls, start priority and async reset.
module tb_instr_encoder;

   logic        clk;
   logic        reset_n;
   logic        start;
`ifdef INSTR_ENCODER_NOP_PAD_EN
   logic        flush;
`endif
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_kind;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [5:0]  in_funct;
   logic [15:0] in_imm;
   logic [25:0] in_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [1:0]  out_addr;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
`ifdef INSTR_ENCODER_NOP_PAD_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kind   (in_kind),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_funct  (in_funct),
      .in_imm    (in_imm),
      .in_target (in_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to 2 time units after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg);
      in_valid  = 1'b1;
      in_kind   = k;
      in_rs     = rs;
      in_rt     = rt;
      in_rd     = rd;
      in_shamt  = 5'd0;
      in_funct  = fn;
      in_imm    = imm;
      in_target = tg;
   endtask

   // ADDI rs=1 rt=2 with a given immediate encodes as 0x2022_imm
   task automatic drive_addi(input logic [15:0] imm);
      drive(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, imm, 26'd0);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 2'd0 ||
          done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: v=%b instr=%h addr=%0d done=%b err=%b rdy=%b, want all 0",
                  out_valid, out_instr, out_addr, done, err, in_ready);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: in_ready=%b want 0", in_ready);
      end
   endtask

   task automatic test_single_addi();
      do_start();
      out_ready = 1'b1;
      drive_addi(16'h0005);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL run_ready: in_ready=%b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h20220005 || out_addr !== 2'd0) begin
         errors++;
         $display("FAIL addi_word: v=%b instr=%h addr=%0d want 1 20220005 0",
                  out_valid, out_instr, out_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL addi_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3];
      exp_w[0] = 32'h00221820;
      exp_w[1] = 32'h8FA80004;
      exp_w[2] = 32'h08000010;
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       drive(3'd0, 5'd1,  5'd2, 5'd3, 6'h20, 16'h0, 26'h0);
            1:       drive(3'd1, 5'd29, 5'd8, 5'd0, 6'h00, 16'h4, 26'h0);
            default: drive(3'd6, 5'd0,  5'd0, 5'd0, 6'h00, 16'h0, 26'h10);
         endcase
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== exp_w[i] || out_addr !== 2'(i)) begin
            errors++;
            $display("FAIL b2b_word%0d: v=%b instr=%h addr=%0d want 1 %h %0d",
                     i, out_valid, out_instr, out_addr, exp_w[i], i);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      do_start();
      out_ready = 1'b1;
      drive_addi(16'h0001);
      tick();
      out_ready = 1'b0;
      drive_addi(16'h0002);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready%0d: in_ready=%b want 0", c, in_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 32'h20220001 || out_addr !== 2'd0) begin
            errors++;
            $display("FAIL bp_hold%0d: v=%b instr=%h addr=%0d want 1 20220001 0",
                     c, out_valid, out_instr, out_addr);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h20220002 || out_addr !== 2'd1) begin
         errors++;
         $display("FAIL bp_resume: v=%b instr=%h addr=%0d want 1 20220002 1",
                  out_valid, out_instr, out_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_nodup: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_full();
      do_start();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_addi(16'h0010 + 16'(i));
         #1;
         checks++;
         if (in_ready !== (i < 4)) begin
            errors++;
            $display("FAIL full_ready%0d: in_ready=%b want %b", i, in_ready, (i < 4));
         end
         tick();
         if (i < 4) begin
            checks++;
            if (out_valid !== 1'b1 || out_addr !== 2'(i) ||
                out_instr !== (32'h20220000 | 32'(16'h0010 + 16'(i)))) begin
               errors++;
               $display("FAIL full_word%0d: v=%b instr=%h addr=%0d", i, out_valid, out_instr, out_addr);
            end
         end
         if (i == 3) begin
            checks++;
            if (done !== 1'b0) begin
               errors++;
               $display("FAIL full_done_early: done=%b want 0", done);
            end
         end
      end
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL full_drained: v=%b done=%b want 0 1", out_valid, done);
      end
      // word 5 still offered: start must win over it this cycle
      start = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_priority: in_ready=%b want 0", in_ready);
      end
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: done=%b v=%b want 0 0", done, out_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 2'd0 || out_instr !== 32'h20220014) begin
         errors++;
         $display("FAIL restart_word: v=%b instr=%h addr=%0d want 1 20220014 0",
                  out_valid, out_instr, out_addr);
      end
      tick();
   endtask

   task automatic test_illegal();
      do_start();
      out_ready = 1'b1;
      drive_addi(16'h000A);
      tick();
      drive(3'd7, 5'd1, 5'd2, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL illegal_ready: in_ready=%b want 1", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_consume: v=%b err=%b want 0 1", out_valid, err);
      end
      drive_addi(16'h000B);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h2022000B || out_addr !== 2'd1 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_next: v=%b instr=%h addr=%0d err=%b want 1 2022000b 1 1",
                  out_valid, out_instr, out_addr, err);
      end
      tick();
      do_start();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL start_clears_err: err=%b want 0", err);
      end
   endtask

   task automatic test_async_reset();
      do_start();
      out_ready = 1'b0;
      drive(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
      tick();
      drive_addi(16'h0033);
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || err !== 1'b1 || out_instr !== 32'h20220033) begin
         errors++;
         $display("FAIL pre_reset: v=%b err=%b instr=%h want 1 1 20220033", out_valid, err, out_instr);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 2'd0 ||
          err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: v=%b instr=%h addr=%0d err=%b done=%b rdy=%b want all 0",
                  out_valid, out_instr, out_addr, err, done, in_ready);
      end
      tick();
      reset_n = 1'b1;
      out_ready = 1'b1;
      tick();
   endtask

`ifdef INSTR_ENCODER_NOP_PAD_EN
   task automatic test_pad();
      do_start();
      out_ready = 1'b1;
      drive_addi(16'h0001);
      tick();
      drive_addi(16'h0002);
      tick();
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pad_enter: v=%b want 0", out_valid);
      end
      for (int a = 2; a < 4; a++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_addr !== 2'(a)) begin
            errors++;
            $display("FAIL pad_nop%0d: v=%b instr=%h addr=%0d want 1 00000000 %0d",
                     a, out_valid, out_instr, out_addr, a);
         end
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL pad_done: v=%b done=%b want 0 1", out_valid, done);
      end
   endtask
`endif

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
      flush     = 1'b0;
`endif
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_kind   = 3'd0;
      in_rs     = 5'd0;
      in_rt     = 5'd0;
      in_rd     = 5'd0;
      in_shamt  = 5'd0;
      in_funct  = 6'd0;
      in_imm    = 16'd0;
      in_target = 26'd0;

      test_reset();
      test_single_addi();
      test_back_to_back();
      test_backpressure();
      test_full();
      test_illegal();
      test_async_reset();
`ifdef INSTR_ENCODER_NOP_PAD_EN
      test_pad();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_instr_encoder
